// File: rtl/fft_drm_pkg.sv
// fft_drm_pkg: shared widths, read latency and sequencer states for the FFT data-RAM read side
package fft_drm_pkg;
  localparam int DRM_ADDR_W     = 9;
  localparam int DRM_DATA_W     = 36;
  localparam int DRM_RD_LATENCY = 2;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} drm_state_e;
endpackage

// File: rtl/fft_drm_skid_fifo.sv
// fft_drm_skid_fifo: small register FIFO with occupancy count that soaks up words still arriving from the RAM
module fft_drm_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic                       rd_clk,
  input  logic                       rd_rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  assign rd_data = mem[rp];
  always_ff @(posedge rd_clk or posedge rd_rst)
    if (rd_rst) begin
      mem   <= '{default: '0};
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_en) begin
        mem[wp] <= wr_data;
        wp      <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
      end
      if (rd_en) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
endmodule

// File: rtl/fft_drm_rd_streamer.sv
// fft_drm_rd_streamer: reads a frame of consecutive RAM words and delivers them as a valid/ready
// stream with last marking, issuing reads only while the skid FIFO has room for every word in flight.
module fft_drm_rd_streamer
  import fft_drm_pkg::*;
#(
  parameter int ADDR_WIDTH = DRM_ADDR_W,
  parameter int DATA_WIDTH = DRM_DATA_W,
  parameter int RD_LATENCY = DRM_RD_LATENCY,
  parameter int SKID_DEPTH = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   frame_len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  ram_rd_clk_en,
  output logic                  ram_rd_oce,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);
  localparam int CW = $clog2(SKID_DEPTH + 1);
  drm_state_e state, state_nx;
  logic [ADDR_WIDTH-1:0] base, cur_base;
  logic [ADDR_WIDTH:0] len, issue_cnt, cur_len, cur_cnt;
  logic [RD_LATENCY-1:0] pipe_v, pipe_l;
  logic [CW-1:0] fifo_count;
  logic [DATA_WIDTH:0] head;
  logic accept, issue, is_last, pop, fin;
  assign accept   = state == IDLE && start && frame_len != '0;
  // The first read launches on the accepting edge, straight from the start inputs
  assign cur_base = accept ? base_addr : base;
  assign cur_len  = accept ? frame_len : len;
  assign cur_cnt  = accept ? '0 : issue_cnt;
  assign is_last  = cur_cnt == cur_len - 1'b1;
  // Credit covers FIFO words plus reads still in the RAM pipe, so the tail write never overflows
  assign issue    = (accept || state == RUN) && cur_cnt < cur_len &&
                    int'(fifo_count) + $countones(pipe_v) < SKID_DEPTH;
  assign m_valid  = fifo_count != '0;
  assign m_data   = head[DATA_WIDTH-1:0];
  assign m_last   = m_valid && head[DATA_WIDTH];
  assign pop      = m_valid && m_ready;
  assign fin      = state == DRAIN && pop && m_last;
  assign ram_rd_clk_en = busy;
  assign ram_rd_oce    = busy;
  always_comb state_nx = fin ? IDLE : (issue && is_last) ? DRAIN : accept ? RUN : state;
  always_ff @(posedge rd_clk or posedge rd_rst)
    if (rd_rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      base        <= '0;
      len         <= '0;
      issue_cnt   <= '0;
      ram_rd_addr <= '0;
      pipe_v      <= '0;
      pipe_l      <= '0;
    end else begin
      state  <= state_nx;
      busy   <= state_nx != IDLE;
      done   <= fin;
      pipe_v <= (pipe_v << 1) | RD_LATENCY'(issue);
      pipe_l <= (pipe_l << 1) | RD_LATENCY'(issue && is_last);
      if (accept) begin
        base <= base_addr;
        len  <= frame_len;
      end
      if (issue) begin
        ram_rd_addr <= cur_base + cur_cnt[ADDR_WIDTH-1:0];
        issue_cnt   <= cur_cnt + 1'b1;
      end
    end
  fft_drm_skid_fifo #(.DEPTH(SKID_DEPTH), .WIDTH(DATA_WIDTH + 1)) u_fifo (
    .rd_clk  (rd_clk),
    .rd_rst  (rd_rst),
    .wr_en   (pipe_v[RD_LATENCY-1]),
    .wr_data ({pipe_l[RD_LATENCY-1], ram_rd_data}),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fifo_count)
  );
endmodule

// File: tb/tb_fft_drm_rd_streamer.sv
// tb_fft_drm_rd_streamer: directed frame table plus reset, zero-length and busy-start sequences
module tb_fft_drm_rd_streamer;
  localparam int AW = 9, DW = 36, SD = 4;
  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            mode;
    bit            inj;
    logic [DW-1:0] last_d;
    string         name;
  } vec_t;
  logic rd_clk = 0, rd_rst = 1, start = 0, m_ready = 0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] frame_len = '0;
  logic busy, done, ram_rd_clk_en, ram_rd_oce, m_valid, m_last;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data, m_data, rdq;
  logic [DW-1:0] mem [512];
  int total = 0, bad = 0;
  vec_t vecs [8];

  fft_drm_rd_streamer dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .start(start), .base_addr(base_addr),
    .frame_len(frame_len), .busy(busy), .done(done), .ram_rd_addr(ram_rd_addr),
    .ram_rd_clk_en(ram_rd_clk_en), .ram_rd_oce(ram_rd_oce), .ram_rd_data(ram_rd_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 rd_clk = ~rd_clk;
  // RAM model: registered address from the DUT plus one output register in this model
  always @(posedge rd_clk) if (ram_rd_clk_en && ram_rd_oce) rdq <= mem[ram_rd_addr];
  assign ram_rd_data = rdq;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge rd_clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v);
    int c, i, first, hs_last, done_cnt, done_c, occ, occ_max, budget;
    logic stalled, bsy;
    logic [DW-1:0] held_d, last_d;
    c = 1; i = 0; first = -1; hs_last = 0; done_cnt = 0; done_c = -1; occ_max = 0;
    stalled = 0; bsy = 1; held_d = '0; last_d = '0;
    budget = int'(v.len) * 4 + 40;
    base_addr = v.base; frame_len = v.len; start = 1; m_ready = 0;
    step;
    start = 0;
    while (c < budget && !(i == int'(v.len) && c > hs_last + 2)) begin
      m_ready = v.mode == 0 ? 1'b1 : v.mode == 1 ? (c % 3 == 0) : 1'($urandom_range(0, 1));
      if (v.inj && c == 4) begin
        start = 1; base_addr = 9'd300; frame_len = 10'd3;
      end else start = 0;
      occ = int'(dut.u_fifo.count) + $countones(dut.pipe_v);
      if (occ > occ_max) occ_max = occ;
      if (m_valid && first < 0) first = c;
      if (stalled) begin
        chk({v.name, "_stall_v"}, m_valid, 1);
        chk({v.name, "_stall_d"}, m_data, held_d);
      end
      if (done) begin
        done_cnt++; done_c = c; bsy = busy;
      end
      if (m_valid && m_ready) begin
        chk({v.name, "_data"}, m_data, DW'(((int'(v.base) + i) % 512) * 3));
        chk({v.name, "_last"}, m_last, i == int'(v.len) - 1);
        i++;
        if (i == int'(v.len)) begin
          hs_last = c; last_d = m_data;
        end
      end
      stalled = m_valid && !m_ready;
      held_d = m_data;
      step;
      c++;
    end
    start = 0; m_ready = 0;
    chk({v.name, "_beats"}, i, v.len);
    chk({v.name, "_first"}, first, 3);
    chk({v.name, "_last_d"}, last_d, v.last_d);
    chk({v.name, "_done_n"}, done_cnt, 1);
    chk({v.name, "_done_c"}, done_c, hs_last + 1);
    chk({v.name, "_busy_at_done"}, bsy, 0);
    chk({v.name, "_occ_le4"}, occ_max <= SD, 1);
    chk({v.name, "_idle_v"}, m_valid, 0);
    if (v.mode == 0) chk({v.name, "_rate"}, hs_last - first, int'(v.len) - 1);
  endtask

  initial begin
    int n, k, seen;
    vec_t rv;
    for (int a = 0; a < 512; a++) mem[a] = DW'(a * 3);
    vecs[0] = '{base: 9'd0,   len: 10'd8,   mode: 0, inj: 0, last_d: 36'd21,   name: "basic"};
    vecs[1] = '{base: 9'd0,   len: 10'd16,  mode: 1, inj: 0, last_d: 36'd45,   name: "bp"};
    vecs[2] = '{base: 9'd510, len: 10'd4,   mode: 0, inj: 0, last_d: 36'd3,    name: "wrap"};
    vecs[3] = '{base: 9'd3,   len: 10'd1,   mode: 0, inj: 0, last_d: 36'd9,    name: "len1"};
    vecs[4] = '{base: 9'd0,   len: 10'd512, mode: 0, inj: 0, last_d: 36'd1533, name: "full"};
    vecs[5] = '{base: 9'd200, len: 10'd20,  mode: 2, inj: 0, last_d: 36'd657,  name: "rnd"};
    vecs[6] = '{base: 9'd508, len: 10'd9,   mode: 1, inj: 0, last_d: 36'd12,   name: "wrap_bp"};
    vecs[7] = '{base: 9'd50,  len: 10'd12,  mode: 1, inj: 1, last_d: 36'd183,  name: "busy_start"};
    repeat (2) step;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", ram_rd_addr, 0);
    chk("rst_clk_en", ram_rd_clk_en, 0);
    chk("rst_oce", ram_rd_oce, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    rd_rst = 0;
    step;
    for (int v = 0; v < 8; v++) begin
      run_frame(vecs[v]);
      repeat (2) step;
    end
    base_addr = 9'd5; frame_len = '0; start = 1; m_ready = 1;
    step;
    start = 0; seen = 0;
    repeat (6) begin
      seen += int'(busy) + int'(done) + int'(m_valid);
      step;
    end
    chk("zero_len_quiet", seen, 0);
    base_addr = '0; frame_len = 10'd10; start = 1; m_ready = 1;
    step;
    start = 0; n = 0; k = 0;
    while (n < 5 && k < 30) begin
      if (m_valid && m_ready) n++;
      step;
      k++;
    end
    chk("mid_beats", n, 5);
    #2 rd_rst = 1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_addr", ram_rd_addr, 0);
    chk("mid_clk_en", ram_rd_clk_en, 0);
    chk("mid_oce", ram_rd_oce, 0);
    chk("mid_valid", m_valid, 0);
    chk("mid_last", m_last, 0);
    chk("mid_data", m_data, 0);
    repeat (2) step;
    rd_rst = 0; seen = 0;
    repeat (5) begin
      seen += int'(busy) + int'(done) + int'(m_valid);
      step;
    end
    chk("post_rst_quiet", seen, 0);
    rv = '{base: 9'd100, len: 10'd2, mode: 0, inj: 0, last_d: 36'd303, name: "after_rst"};
    run_frame(rv);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
